// File: rtl/aes192_key_expand.sv
// AES-192 key-schedule engine: expands a 192-bit key into 13 round keys, one word per cycle.
// Optional AES192KEXP_INV_MIX_EN stores rk1..rk11 through InvMixColumns (equivalent inverse cipher).

module aes192_kexp_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[{~a, 3'b000} +: 8];
endmodule

module aes192_key_expand #(
  parameter int NUM_RK    = 13,
  parameter int RK_WIDTH  = 128,
  parameter int KEY_WIDTH = 192
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [KEY_WIDTH-1:0] key_in,
  input  logic                 key_valid,
  output logic                 key_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 rk_valid,
  input  logic [3:0]           rk_idx,
  output logic [RK_WIDTH-1:0]  rk_dout
);
  // Handshake: a key is taken on a rising edge where key_valid and key_ready are both high.
  // key_valid may stay asserted across a schedule; it has no effect while key_ready is low.

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t              state_q, state_d;
  logic [31:0]         win [6];
  logic [RK_WIDTH-1:0] bank [NUM_RK];
  logic [5:0]          idx_q;
  logic [2:0]          phase_q;
  logic [7:0]          rcon_q;
  logic                rk_valid_q;
  logic                accept;
  logic [31:0]         rot_w, sub_w, t_w, new_w, new_store, w4_store, w5_store;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

`ifdef AES192KEXP_INV_MIX_EN
  function automatic logic [7:0] mul_inv(input logic [7:0] b, input logic [1:0] sel);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (sel)
      2'd0:    return x8 ^ x4 ^ x2;  // *0e
      2'd1:    return x8 ^ x2 ^ b;   // *0b
      2'd2:    return x8 ^ x4 ^ b;   // *0d
      default: return x8 ^ b;        // *09
    endcase
  endfunction

  function automatic logic [31:0] inv_mix(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {mul_inv(a0, 2'd0) ^ mul_inv(a1, 2'd1) ^ mul_inv(a2, 2'd2) ^ mul_inv(a3, 2'd3),
            mul_inv(a0, 2'd3) ^ mul_inv(a1, 2'd0) ^ mul_inv(a2, 2'd1) ^ mul_inv(a3, 2'd2),
            mul_inv(a0, 2'd2) ^ mul_inv(a1, 2'd3) ^ mul_inv(a2, 2'd0) ^ mul_inv(a3, 2'd1),
            mul_inv(a0, 2'd1) ^ mul_inv(a1, 2'd2) ^ mul_inv(a2, 2'd3) ^ mul_inv(a3, 2'd0)};
  endfunction

  // Words 4..47 belong to rk1..rk11; the last four (rk12) stay raw.
  assign new_store = (idx_q <= 6'd47) ? inv_mix(new_w) : new_w;
  assign w4_store  = inv_mix(key_in[63:32]);
  assign w5_store  = inv_mix(key_in[31:0]);
`else
  assign new_store = new_w;
  assign w4_store  = key_in[63:32];
  assign w5_store  = key_in[31:0];
`endif

  // Next word from the raw sliding window: win[0] = w[i-6], win[5] = w[i-1].
  assign rot_w = {win[5][23:0], win[5][31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes192_kexp_sbox u_sbox (.a(rot_w[8*g +: 8]), .y(sub_w[8*g +: 8]));
  end

  assign t_w      = (phase_q == 3'd0) ? (sub_w ^ {rcon_q, 24'h0}) : win[5];
  assign new_w    = win[0] ^ t_w;
  assign accept   = key_valid && key_ready;
  assign rk_valid = rk_valid_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    key_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) state_d = EXPAND;
      end
      EXPAND: begin
        busy = 1'b1;
        if (idx_q == 6'd51) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int k = 0; k < 6; k++) win[k] <= '0;
      for (int k = 0; k < NUM_RK; k++) bank[k] <= '0;
      idx_q      <= '0;
      phase_q    <= '0;
      rcon_q     <= '0;
      rk_valid_q <= 1'b0;
      rk_dout    <= '0;
    end else begin
      // Read uses pre-edge bank contents even when a write lands on the same edge.
      if (rk_idx < 4'(NUM_RK)) rk_dout <= bank[rk_idx];
      else                     rk_dout <= '0;

      if (accept) begin
        for (int k = 0; k < 6; k++) win[k] <= key_in[KEY_WIDTH-1-32*k -: 32];
        bank[0]         <= key_in[KEY_WIDTH-1 -: 128];
        bank[1][127:64] <= {w4_store, w5_store};
        idx_q           <= 6'd6;
        phase_q         <= 3'd0;
        rcon_q          <= 8'h01;
        rk_valid_q      <= 1'b0;
      end else if (busy) begin
        for (int k = 0; k < 5; k++) win[k] <= win[k+1];
        win[5] <= new_w;
        // Word i lands in round key i/4, slot i%4 counted from the top.
        bank[idx_q[5:2]][{~idx_q[1:0], 5'b00000} +: 32] <= new_store;
        idx_q   <= idx_q + 6'd1;
        phase_q <= (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
        if (phase_q == 3'd0) rcon_q <= xtime(rcon_q);
        if (idx_q == 6'd51) rk_valid_q <= 1'b1;
      end
    end
  end
endmodule

// File: doc/aes192_key_expand.md
# aes192_key_expand

AES-192 key-schedule engine for the decryption datapath. It accepts a 192-bit cipher key over a valid/ready handshake and expands it, one 32-bit word per cycle, into the 13 round keys (128 bits each). The keys are stored in an internal register bank. A 4-bit index read port returns one round key, so this block is the producer feeding the round-key selector in the decryption round loop.

## Interface
Parameters are fixed; changing them is unsupported.
- NUM_RK, 13, number of round keys stored
- RK_WIDTH, 128, round-key width in bits
- KEY_WIDTH, 192, cipher-key width in bits

Ports:
- ap_clk  in  1  single clock; all logic on rising edge
- ap_rst_n  in  1  reset, asynchronous, active-low
- key_in  in  192  cipher key; [191:160] is w0, [31:0] is w5
- key_valid  in  1  key_in valid
- key_ready  out  1  engine idle, can accept a key
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse when schedule complete
- rk_valid  out  1  bank holds a complete schedule
- rk_idx  in  4  round-key index 0..12
- rk_dout  out  128  round key rk_idx, registered; w[4r] in [127:96]

## Operation
- Reset values: key_ready=1, busy=0, done=0, rk_valid=0, rk_dout=0. All bank entries, the window and the counters clear to 0.
- FSM states: IDLE, EXPAND, DONE.
- **IDLE**
  - key_ready=1.
  - On key_valid&&key_ready: latch w0..w5 into the 6-word sliding window and write them to bank words 0..5.
  - Set i=6, rcon=0x01, rk_valid=0, and go to EXPAND.
  - key_valid while not in IDLE is ignored.
- **EXPAND**
  - busy=1, key_ready=0.
  - Each cycle computes w[i] = w[i-6] ^ t.
  - t = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0} when i mod 6 == 0; otherwise t = w[i-1].
  - After each rcon use, rcon <= xtime(rcon), giving 01,02,04,08,10,20,40,80.
  - Write w[i] into round key i/4, word slot i%4; slot 0 is [127:96].
  - Shift the window and increment i.
  - After i=51 is written, go to DONE.
- SubWord uses four combinational AES forward S-box instances.
- **DONE**
  - One cycle: done=1, rk_valid=1 (held until the next key is accepted), busy=0.
  - Next state is IDLE.
- **Read port**
  - rk_dout <= bank[rk_idx] every cycle, independent of FSM state.
  - rk_idx 13..15 returns 128'h0.
  - Reading during EXPAND returns partially updated contents; consumers must gate on rk_valid.
- **Reset mid-expansion:** bank, window and FSM clear immediately; rk_valid=0. No done pulse is emitted.

## Timing
- The handshake completes at edge 0, when key_valid&&key_ready are sampled high.
- EXPAND occupies cycles 1..46, one word per cycle for i=6..51.
- DONE (done=1) is cycle 47; key_ready returns to 1 in cycle 48.
- rk_valid rises with done and stays high until the next key is accepted.
- Back-to-back keys: throughput is one key per 48 cycles.
- Read latency is 1 cycle from rk_idx to rk_dout.
- Simultaneous key acceptance and read: the read returns the pre-edge bank contents.

## Configuration
- Macro AES192KEXP_INV_MIX_EN.
- **Defined:** words written for round keys 1..11 (i=4..47) are transformed by InvMixColumns before storage, giving the equivalent-inverse-cipher schedule.
  - Round keys 0 and 12 are stored raw.
  - The sliding window always holds raw words.
  - Latency is unchanged; InvMixColumns is combinational on the write path.
- **Undefined:** all 52 words are stored raw, in standard FIPS-197 order.

## Test plan
- **FIPS-197 A.2 schedule**
  - Stimulus: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, macro off.
  - Required: rk1[63:32]=fe0c91f7; rk12=e98ba06f448c773c8ecc720401002202; done exactly 47 cycles after the handshake.
- **FIPS-197 C.2 schedule**
  - Stimulus: key 000102…1617, macro off.
  - Required: rk0=000102030405060708090a0b0c0d0e0f; rk12=a4970a331a78dc09c418c271e3a41d5d.
- **Handshake and back-to-back keys**
  - Stimulus: key_valid held high through busy; second key presented at cycle 48.
  - Required: only one acceptance per schedule; key_ready low in cycles 1..47; second schedule completes at cycle 95.
  - Also rk_valid drops at the second handshake and rises at the second done.
- **Reset mid-expansion**
  - Stimulus: ap_rst_n low at cycle 20 for 2 cycles.
  - Required: rk_valid=0; all rk_idx reads return 0; no done pulse; key_ready=1 after release.
  - A restarted key then expands correctly.
- **Read port bounds**
  - Stimulus: after A.2 completes, sweep rk_idx 0..15.
  - Required: correct keys for 0..12 one cycle later; 128'h0 for 13..15.
- **Macro on**
  - Stimulus: A.2 key.
  - Required: rk0 and rk12 unchanged; rk1..rk11 equal InvMixColumns of the raw keys, checked against the reference model.
